// File: rtl/lsu_pipelined.sv
// Load/store unit for the MEM stage: one access per handshake, word-addressed memory port with
// grant/rvalid handshake, byte strobes, load extension and optional two-word misaligned split.
module lsu_pipelined #(
  parameter int ADDR_W         = 7,
  parameter bit MISALIGN_SPLIT = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_fun3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic [4:0]        rsp_rd,
  output logic              rsp_err,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  // States: IDLE accept | REQ0/REQ1 word request until gnt | WAIT0/WAIT1 await rvalid |
  //         RESP one-cycle completion pulse
  typedef enum logic [2:0] {
    S_IDLE, S_REQ0, S_WAIT0, S_REQ1, S_WAIT1, S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        fun3_q, fun3_d;
  logic [1:0]        off_q, off_d;
  logic              cross_q, cross_d;
  logic              err_q, err_d;
  logic [4:0]        rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        strb_q, strb_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [31:0]       word0_q, word0_d;
  logic [31:0]       word1_q, word1_d;

  logic [1:0] in_off;
  logic [3:0] in_mask;
  logic [2:0] in_bytes;
  logic       in_illegal;
  logic       in_cross;

  always_comb begin
    in_off   = req_addr[1:0];
    in_mask  = 4'b0001;
    in_bytes = 3'd1;
    case (req_fun3[1:0])
      2'b01:   begin in_mask = 4'b0011; in_bytes = 3'd2; end
      2'b10:   begin in_mask = 4'b1111; in_bytes = 3'd4; end
      default: ;
    endcase
    // unsigned variants exist only for loads
    in_illegal = (req_fun3[1:0] == 2'b11) || (req_fun3 == 3'b110) || (req_fun3[2] && req_we);
    in_cross   = ({1'b0, in_off} + in_bytes) > 3'd4;
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    fun3_d  = fun3_q;
    off_d   = off_q;
    cross_d = cross_q;
    err_d   = err_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    strb_d  = strb_q;
    wdata_d = wdata_q;
    word0_d = word0_q;
    word1_d = word1_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          fun3_d  = req_fun3;
          off_d   = in_off;
          rd_d    = req_rd;
          addr_d  = req_addr[ADDR_W+1:2];
          strb_d  = {4'b0000, in_mask} << in_off;
          wdata_d = {32'h0, req_wdata} << {in_off, 3'b000};
          cross_d = in_cross;
          word0_d = '0;
          word1_d = '0;
          if (in_illegal || (in_cross && !MISALIGN_SPLIT)) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = S_REQ0;
          end
        end
      end
      S_REQ0: begin
        if (mem_gnt) begin
          if (we_q) state_d = cross_q ? S_REQ1 : S_RESP;
          else      state_d = S_WAIT0;
        end
      end
      S_WAIT0: begin
        if (mem_rvalid) begin
          word0_d = mem_rdata;
          state_d = cross_q ? S_REQ1 : S_RESP;
        end
      end
      S_REQ1: begin
        if (mem_gnt) state_d = we_q ? S_RESP : S_WAIT1;
      end
      S_WAIT1: begin
        if (mem_rvalid) begin
          word1_d = mem_rdata;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      fun3_q  <= 3'b000;
      off_q   <= 2'b00;
      cross_q <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 5'd0;
      addr_q  <= '0;
      strb_q  <= 8'h00;
      wdata_q <= 64'h0;
      word0_q <= 32'h0;
      word1_q <= 32'h0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      fun3_q  <= fun3_d;
      off_q   <= off_d;
      cross_q <= cross_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      strb_q  <= strb_d;
      wdata_q <= wdata_d;
      word0_q <= word0_d;
      word1_q <= word1_d;
    end
  end

  logic in_req1;
  assign in_req1   = (state_q == S_REQ1);
  assign mem_req   = (state_q == S_REQ0) || in_req1;
  assign mem_we    = mem_req && we_q;
  // second word wraps at the top of the word-address space
  assign mem_addr  = mem_req ? (in_req1 ? addr_q + ADDR_W'(1) : addr_q) : '0;
  assign mem_wdata = mem_req ? (in_req1 ? wdata_q[63:32] : wdata_q[31:0]) : 32'h0;
  assign mem_wstrb = mem_req ? (in_req1 ? strb_q[7:4] : strb_q[3:0]) : 4'h0;

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rd    = rd_q;
  assign stall     = (state_q != S_IDLE && state_q != S_RESP) || (state_q == S_IDLE && req_valid);

  logic [63:0] ld_cat;
  logic [31:0] ld_sh;
  logic [31:0] ld_ext;

  always_comb begin
    ld_cat = {word1_q, word0_q} >> {off_q, 3'b000};
    ld_sh  = ld_cat[31:0];
    case (fun3_q)
      3'b000:  ld_ext = {{24{ld_sh[7]}}, ld_sh[7:0]};
      3'b001:  ld_ext = {{16{ld_sh[15]}}, ld_sh[15:0]};
      3'b100:  ld_ext = {24'h0, ld_sh[7:0]};
      3'b101:  ld_ext = {16'h0, ld_sh[15:0]};
      default: ld_ext = ld_sh;
    endcase
  end

  assign rsp_rdata = (rsp_valid && !we_q && !err_q) ? ld_ext : 32'h0;

  logic unused_bits;
  assign unused_bits = ^{req_addr[31:ADDR_W+2], ld_cat[63:32]};

endmodule

// File: doc/lsu_pipelined.md
# lsu_pipelined

Parametrised load/store unit sitting in the MEM stage of the RV32I pipeline, replacing the fixed single-cycle data-memory binding. Accepts one access per handshake from the MEM stage, drives a word-addressed memory port with a grant/rvalid handshake, and generates byte strobes. Sign- or zero-extends load data and optionally splits misaligned accesses into two word transactions. Stalls the pipeline until the access completes.

## Interface
- ADDR_W, 7, word-address width of the memory port (byte address bits [ADDR_W+1:2] used)
- MISALIGN_SPLIT, 1, 1: split word-crossing accesses into two transactions; 0: report error, no memory access
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- req_valid  in  1  MEM stage presents an access
- req_ready  out  1  LSU can accept (IDLE only)
- req_we  in  1  1 = store, 0 = load
- req_fun3  in  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
- req_addr  in  32  byte address
- req_wdata  in  32  store data (rs2), right-aligned
- req_rd  in  5  destination register, echoed on response
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data (0 for stores/errors)
- rsp_rd  out  5  echoed req_rd
- rsp_err  out  1  misaligned (MISALIGN_SPLIT=0) or illegal funct3
- stall  out  1  hold pipeline
- mem_req  out  1  memory request
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  lane-aligned write data
- mem_wstrb  out  4  byte-lane strobes
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read data

## Operation
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- IDLE: req_ready=1. On req_valid, latch all req_* fields; off = addr[1:0], size mask = 0001/0011/1111.
- Illegal funct3 (011, 110, 111, or 100/101 with req_we=1): go straight to RESP with rsp_err=1; no mem_req.
- Crossing = (off + bytes) > 4. Crossing and MISALIGN_SPLIT=0: RESP with rsp_err=1, no access. Otherwise -> REQ0.
- Strobes: s = mask << off (8 bits); first access wstrb = s[3:0], second = s[7:4]. Write data = (wdata << 8*off), low word first, high word second.
- REQ0: mem_req=1, mem_addr = addr[ADDR_W+1:2]. On mem_gnt: store -> REQ1 if crossing else RESP; load -> WAIT0.
- WAIT0: on mem_rvalid capture word0; -> REQ1 if crossing else RESP.
- REQ1: mem_addr = first address + 1, modulo 2^ADDR_W (wraps to 0). On gnt: store -> RESP; load -> WAIT1.
- WAIT1: on mem_rvalid capture word1 -> RESP.
- Load result: ({word1, word0} >> 8*off) truncated to size; sign-extend for 000/001, zero-extend for 100/101; word unchanged.
- RESP: rsp_valid=1 one cycle, -> IDLE.
- mem_rvalid outside WAIT0/WAIT1 is ignored.
- stall = (state ∉ {IDLE, RESP}) | (state==IDLE & req_valid).

## Timing
- Reset: state IDLE; all outputs 0 except req_ready=1. Reset mid-transaction aborts it: mem_req low from the cycle after reset, no rsp_valid, pending rvalid dropped.
- mem_req, mem_addr, mem_we, mem_wdata, mem_wstrb registered-stable while mem_req=1 until gnt.
- Minimum latency (gnt and rvalid one cycle later, zero wait): aligned store rsp_valid at accept+2; aligned load accept+3; split store accept+3; split load accept+5; error accept+1.
- rsp_* fields valid only while rsp_valid=1; rsp_rd always echoed.
- Back-to-back: new request accepted the cycle after RESP (IDLE).

## Test plan
- Aligned SW addr 0x10, data 0xDEADBEEF, gnt immediate -> mem_addr=4, wstrb=1111, wdata=0xDEADBEEF, rsp_valid at cycle 2, rsp_err=0.
- LB addr 0x13, mem_rdata=0x80FF0000 -> wstrb irrelevant, rsp_rdata=0xFFFFFF80; same with LBU -> 0x00000080.
- MISALIGN_SPLIT=1, SW addr 0x06 data 0x11223344 -> access1 addr 1 wstrb 1100 wdata 0x33440000; access2 addr 2 wstrb 0011 wdata 0x00001122.
- MISALIGN_SPLIT=1, LH addr 0x1FF (ADDR_W=7), word0=0xAB000000, word1=0x000000CD -> second mem_addr wraps to 0, rsp_rdata=0xFFFFCDAB.
- MISALIGN_SPLIT=0, LW addr 0x02 -> no mem_req, rsp_valid at accept+1, rsp_err=1; funct3=011 likewise.
- LW with gnt delayed 3 cycles then rst asserted in WAIT0 -> mem_req low next cycle, no rsp_valid, late rvalid ignored, req_ready=1 after reset.
